cpu_bus_arb: RTL and testbench

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

---
 rtl/cpu_bus_arb_if.sv | 42 ++++
 rtl/cpu_bus_arb.sv | 153 +++++++++++++++
 tb/tb_cpu_bus_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arb_if.sv
// Bundle of the two CPU master ports and the shared slave bus seen by cpu_bus_arb.
// The arbiter connects through the slave modport; the environment drives through master.
interface cpu_bus_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] im0_addr;
    logic [DATA_WIDTH-1:0] im0_data;
    logic                  im0_wr;
    logic                  im0_rd;
    logic                  om0_ack;
    logic [DATA_WIDTH-1:0] om0_rdata;

    logic [ADDR_WIDTH-1:0] im1_addr;
    logic [DATA_WIDTH-1:0] im1_data;
    logic                  im1_wr;
    logic                  im1_rd;
    logic                  om1_ack;
    logic [DATA_WIDTH-1:0] om1_rdata;

    logic [ADDR_WIDTH-1:0] oaddr;
    logic [DATA_WIDTH-1:0] odata;
    logic                  owr;
    logic                  ord;
    logic [DATA_WIDTH-1:0] idata;

    modport slave (
        input  im0_addr, im0_data, im0_wr, im0_rd,
        input  im1_addr, im1_data, im1_wr, im1_rd,
        input  idata,
        output om0_ack, om0_rdata, om1_ack, om1_rdata,
        output oaddr, odata, owr, ord
    );

    modport master (
        output im0_addr, im0_data, im0_wr, im0_rd,
        output im1_addr, im1_data, im1_wr, im1_rd,
        output idata,
        input  om0_ack, om0_rdata, om1_ack, om1_rdata,
        input  oaddr, odata, owr, ord
    );
endinterface

// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: two-master / one-slave arbiter issuing fixed-length write or read strobes.
// Optional macro CPU_BUS_ARB_FIXED_PRIO_EN: master 0 always wins instead of round-robin.
module cpu_bus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WR_WAIT    = 5,
    parameter int RD_WAIT    = 5
) (
    input  logic         iclk,
    input  logic         irst,
    cpu_bus_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    localparam logic [7:0] WR_LAST = 8'(WR_WAIT - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  win_q, win_d;
    logic                  dir_wr_q, dir_wr_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  owr_q, owr_d;
    logic                  ord_q, ord_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic req0, req1, grant1, sel_wr, last_xfer;

    assign req0 = bus.im0_wr | bus.im0_rd;
    assign req1 = bus.im1_wr | bus.im1_rd;

`ifdef CPU_BUS_ARB_FIXED_PRIO_EN
    assign grant1 = req1 & ~req0;
`else
    // last_q high means master 1 was served last, so master 0 wins the next tie.
    logic last_q, last_d;
    assign grant1 = req1 & (~req0 | ~last_q);
`endif

    // Write takes precedence when a master raises both levels.
    assign sel_wr    = grant1 ? bus.im1_wr : bus.im0_wr;
    assign last_xfer = (cnt_q == (dir_wr_q ? WR_LAST : RD_LAST));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        dir_wr_d = dir_wr_q;
        oaddr_d  = oaddr_q;
        odata_d  = odata_q;
        owr_d    = owr_q;
        ord_d    = ord_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifndef CPU_BUS_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req0 | req1) begin
                    state_d  = XFER;
                    win_d    = grant1;
                    dir_wr_d = sel_wr;
                    oaddr_d  = grant1 ? bus.im1_addr : bus.im0_addr;
                    odata_d  = grant1 ? bus.im1_data : bus.im0_data;
                    owr_d    = sel_wr;
                    ord_d    = ~sel_wr;
`ifndef CPU_BUS_ARB_FIXED_PRIO_EN
                    last_d   = grant1;
`endif
                end
            end
            XFER: begin
                if (last_xfer) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                    owr_d   = 1'b0;
                    ord_d   = 1'b0;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    if (!dir_wr_q) begin
                        if (win_q) rdata1_d = bus.idata;
                        else       rdata0_d = bus.idata;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owr_d   = 1'b0;
                ord_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            win_q    <= 1'b0;
            dir_wr_q <= 1'b0;
            oaddr_q  <= '0;
            odata_q  <= '0;
            owr_q    <= 1'b0;
            ord_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef CPU_BUS_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            dir_wr_q <= dir_wr_d;
            oaddr_q  <= oaddr_d;
            odata_q  <= odata_d;
            owr_q    <= owr_d;
            ord_q    <= ord_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef CPU_BUS_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.oaddr     = oaddr_q;
    assign bus.odata     = odata_q;
    assign bus.owr       = owr_q;
    assign bus.ord       = ord_q;
    assign bus.om0_ack   = ack0_q;
    assign bus.om1_ack   = ack1_q;
    assign bus.om0_rdata = rdata0_q;
    assign bus.om1_rdata = rdata1_q;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Bench for cpu_bus_arb: dut_a (WR_WAIT=5, RD_WAIT=3) checked by a scoreboard monitor,
// dut_b (both waits 1) checked by hand-written single-cycle strobe sequences.
module tb_cpu_bus_arb;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    int   cyc  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    cpu_bus_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    cpu_bus_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    cpu_bus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WR_WAIT(5), .RD_WAIT(3)) dut_a (
        .iclk(iclk), .irst(irst), .bus(bus_a));
    cpu_bus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WR_WAIT(1), .RD_WAIT(1)) dut_b (
        .iclk(iclk), .irst(irst), .bus(bus_b));

    typedef struct {
        int          m;
        bit          wr;
        int          len;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          ack_cyc;
    } sb_t;

    typedef struct {
        int          m;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] idata;
        bit          exp_wr;
        int          exp_len;
        logic [31:0] exp_rdata;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic sb_t mk_sb(input int m, input bit wr, input int len, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [31:0] rdata, input int ack_cyc);
        sb_t s;
        s.m = m; s.wr = wr; s.len = len; s.addr = addr; s.data = data; s.rdata = rdata;
        s.ack_cyc = ack_cyc;
        return s;
    endfunction

    // ---------------- scoreboard monitor on dut_a ----------------
    int          slen = 0;
    bit          s_wr, stable_bad, post_ack;
    logic [31:0] s_addr, s_data;
    sb_t         me;

    always @(negedge iclk) begin
        if (!irst) begin
            slen = 0; stable_bad = 0; post_ack = 0;
        end else begin
            if (post_ack) begin
                chk("idle_after_ack", {bus_a.owr, bus_a.ord, bus_a.om0_ack, bus_a.om1_ack}, 0);
                post_ack = 0;
            end
            if (bus_a.owr || bus_a.ord) begin
                chk("strobe_excl", bus_a.owr & bus_a.ord, 0);
                if (slen == 0) begin
                    s_addr = bus_a.oaddr; s_data = bus_a.odata; s_wr = bus_a.owr;
                end else if (bus_a.oaddr !== s_addr || bus_a.odata !== s_data || bus_a.owr !== s_wr) begin
                    stable_bad = 1;
                end
                slen++;
            end
            if (bus_a.om0_ack || bus_a.om1_ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", {bus_a.om1_ack, bus_a.om0_ack}, 0);
                end else begin
                    me = sbq.pop_front();
                    chk("ack_master", {bus_a.om1_ack, bus_a.om0_ack}, (me.m == 0) ? 2'b01 : 2'b10);
                    chk("done_strobe_off", {bus_a.owr, bus_a.ord}, 0);
                    chk("strobe_dir", s_wr, me.wr);
                    chk("strobe_len", slen, me.len);
                    chk("strobe_addr", s_addr, me.addr);
                    chk("strobe_data", s_data, me.data);
                    chk("strobe_stable", stable_bad, 0);
                    chk("rdata", (me.m == 0) ? bus_a.om0_rdata : bus_a.om1_rdata, me.rdata);
                    if (me.ack_cyc >= 0) chk("ack_latency", cyc, me.ack_cyc);
                end
                slen = 0; stable_bad = 0; post_ack = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv_a(input int m, input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data);
        if (m == 0) begin
            bus_a.im0_wr = wr; bus_a.im0_rd = rd; bus_a.im0_addr = addr; bus_a.im0_data = data;
        end else begin
            bus_a.im1_wr = wr; bus_a.im1_rd = rd; bus_a.im1_addr = addr; bus_a.im1_data = data;
        end
    endtask

    task automatic wait_ack_a(input int m);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge iclk); #1;
            if ((m == 0 && bus_a.om0_ack) || (m == 1 && bus_a.om1_ack)) begin
                ok = 1;
                break;
            end
        end
        chk("ack_timeout", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;

        vt[0] = '{0, 1'b1, 1'b0, 32'h10,       32'hA5,       32'h0,        1'b1, 5, 32'h0};
        vt[1] = '{1, 1'b0, 1'b1, 32'h20,       32'h0,        32'h1234,     1'b0, 3, 32'h1234};
        vt[2] = '{0, 1'b1, 1'b1, 32'h30,       32'h5A,       32'h9999,     1'b1, 5, 32'h0};
        vt[3] = '{0, 1'b0, 1'b1, 32'h44,       32'h1,        32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF};
        vt[4] = '{1, 1'b1, 1'b0, 32'h88,       32'hCAFE,     32'h5555,     1'b1, 5, 32'h1234};
        vt[5] = '{1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h2,        32'hFFFFFFFF, 1'b0, 3, 32'hFFFFFFFF};
        vt[6] = '{0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h7777,     1'b1, 5, 32'hDEADBEEF};

        drv_a(0, 0, 0, 0, 0);
        drv_a(1, 0, 0, 0, 0);
        bus_a.idata = 0;
        bus_b.im0_wr = 0; bus_b.im0_rd = 0; bus_b.im0_addr = 0; bus_b.im0_data = 0;
        bus_b.im1_wr = 0; bus_b.im1_rd = 0; bus_b.im1_addr = 0; bus_b.im1_data = 0;
        bus_b.idata = 0;

        #2 irst = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_ctrl", {bus_a.owr, bus_a.ord, bus_a.om0_ack, bus_a.om1_ack}, 0);
        chk("rst_addr_data", {bus_a.oaddr, bus_a.odata}, 0);
        chk("rst_rdata", {bus_a.om0_rdata, bus_a.om1_rdata}, 0);

        // Contention from reset: both masters hold requests continuously.
        drv_a(0, 1, 0, 32'h100, 32'h11);
        drv_a(1, 0, 1, 32'h200, 32'h22);
        bus_a.idata = 32'h0BADF00D;
`ifdef CPU_BUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) sbq.push_back(mk_sb(0, 1, 5, 32'h100, 32'h11, 32'h0, -1));
`else
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(mk_sb(0, 1, 5, 32'h100, 32'h11, 32'h0, -1));
            sbq.push_back(mk_sb(1, 0, 3, 32'h200, 32'h22, 32'h0BADF00D, -1));
        end
`endif
        @(posedge iclk); #1;
        irst = 1'b1;
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(posedge iclk); #1;
            if (bus_a.om0_ack || bus_a.om1_ack) acks++;
        end
        chk("contention_acks", acks, 4);
        @(posedge iclk); #1;
        drv_a(0, 0, 0, 0, 0);
        drv_a(1, 0, 0, 0, 0);
        repeat (3) @(posedge iclk);

        // Table-driven single-requester transactions.
        foreach (vt[i]) begin
            @(posedge iclk); #1;
            bus_a.idata = vt[i].idata;
            drv_a(vt[i].m, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data);
            sbq.push_back(mk_sb(vt[i].m, vt[i].exp_wr, vt[i].exp_len, vt[i].addr, vt[i].data,
                                vt[i].exp_rdata, cyc + vt[i].exp_len + 1));
            wait_ack_a(vt[i].m);
            @(posedge iclk); #1;
            drv_a(vt[i].m, 0, 0, 0, 0);
            repeat (2) @(posedge iclk);
        end

        // Reset during the second write strobe cycle, then complete after release.
        @(posedge iclk); #1;
        drv_a(0, 1, 0, 32'h60, 32'h77);
        repeat (2) @(posedge iclk);
        #1;
        chk("pre_reset_strobe", bus_a.owr, 1);
        irst = 1'b0;
        #1;
        chk("rst_async_ctrl", {bus_a.owr, bus_a.ord, bus_a.om0_ack, bus_a.om1_ack}, 0);
        chk("rst_async_addr", {bus_a.oaddr, bus_a.odata}, 0);
        chk("rst_async_rdata", {bus_a.om0_rdata, bus_a.om1_rdata}, 0);
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge iclk); #1;
            chk("rst_no_ack", {bus_a.om0_ack, bus_a.om1_ack, bus_a.owr}, 0);
        end
        irst = 1'b1;
        sbq.push_back(mk_sb(0, 1, 5, 32'h60, 32'h77, 32'h0, cyc + 6));
        wait_ack_a(0);
        @(posedge iclk); #1;
        drv_a(0, 0, 0, 0, 0);
        repeat (3) @(posedge iclk);
        chk("sb_drain", sbq.size(), 0);

        // One-cycle strobes on dut_b: master 1 write, then master 0 read.
        @(posedge iclk); #1;
        bus_b.im1_wr = 1; bus_b.im1_addr = 32'h5; bus_b.im1_data = 32'h9;
        @(posedge iclk); #1;
        chk("b_wr_strobe", {bus_b.owr, bus_b.ord, bus_b.om0_ack, bus_b.om1_ack}, 4'b1000);
        chk("b_wr_bus", {bus_b.oaddr, bus_b.odata}, {32'h5, 32'h9});
        @(posedge iclk); #1;
        chk("b_wr_ack", {bus_b.owr, bus_b.ord, bus_b.om0_ack, bus_b.om1_ack}, 4'b0001);
        @(posedge iclk); #1;
        chk("b_wr_after", {bus_b.owr, bus_b.ord, bus_b.om0_ack, bus_b.om1_ack}, 4'b0000);
        bus_b.im1_wr = 0;
        @(posedge iclk); #1;
        bus_b.im0_rd = 1; bus_b.im0_addr = 32'hAB; bus_b.idata = 32'h77;
        @(posedge iclk); #1;
        chk("b_rd_strobe", {bus_b.owr, bus_b.ord, bus_b.om0_ack, bus_b.om1_ack}, 4'b0100);
        @(posedge iclk); #1;
        chk("b_rd_ack", {bus_b.owr, bus_b.ord, bus_b.om0_ack, bus_b.om1_ack}, 4'b0010);
        chk("b_rd_rdata", {bus_b.om0_rdata, bus_b.om1_rdata}, {32'h77, 32'h0});
        @(posedge iclk); #1;
        bus_b.im0_rd = 0;
        repeat (2) @(posedge iclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
